ahb_mtx_rr_arb: RTL and testbench

- Output-stage arbiter for one AHB bus-matrix output port.
- Round-robin between NUM_PORTS input stages; replaces the fixed-priority output arbitration on slaves where fairness matters.
- Drives the output-stage mux select (addr_in_port/no_port).
- Honours HMASTLOCKM; optionally holds the grant for defined-length bursts.

---
 rtl/ahb_mtx_rr_arb.sv | 111 +++++++++++
 tb/tb_ahb_mtx_rr_arb.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/ahb_mtx_rr_arb.sv
// ahb_mtx_rr_arb: round-robin output-stage arbiter for one AHB matrix port.
// Optional burst grant hold is enabled by defining AHB_MTX_RR_BURST_HOLD_EN.
module ahb_mtx_rr_arb #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = 3
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic [NUM_PORTS-1:0] req_port,
    input  logic                 HREADYM,
    input  logic                 HSELM,
    input  logic [1:0]           HTRANSM,
    input  logic [2:0]           HBURSTM,
    input  logic                 HMASTLOCKM,
    output logic [PORT_W-1:0]    addr_in_port,
    output logic                 no_port,
    output logic                 burst_hold
);
`ifdef AHB_MTX_RR_BURST_HOLD_EN
    typedef enum logic [1:0] {IDLE, GRANT, LOCK, BURST} state_e;
`else
    typedef enum logic [1:0] {IDLE, GRANT, LOCK} state_e;
`endif
    state_e state_q, state_d;
    logic [PORT_W-1:0] addr_q, addr_d, rr_q, rr_d, win;
    logic [2**PORT_W-1:0] req_pad;
    logic [PORT_W:0] idx;
    logic found;

    assign req_pad = (2**PORT_W)'(req_port);

    // Scan from the highest offset down so the lowest offset from rr_q wins.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            idx = {1'b0, rr_q} + (PORT_W+1)'(k);
            idx = (idx >= (PORT_W+1)'(NUM_PORTS)) ? idx - (PORT_W+1)'(NUM_PORTS) : idx;
            if (req_pad[idx[PORT_W-1:0]]) begin
                win   = idx[PORT_W-1:0];
                found = 1'b1;
            end
        end
    end

`ifdef AHB_MTX_RR_BURST_HOLD_EN
    logic [3:0] beat_q, beat_d, load_val;
    logic hold_q, freeze;

    always_comb begin
        load_val = (HBURSTM[2:1] == 2'b01) ? 4'd3
                 : (HBURSTM[2:1] == 2'b10) ? 4'd7
                 : (HBURSTM[2:1] == 2'b11) ? 4'd15 : 4'd0;
        beat_d   = (HSELM && HTRANSM == 2'b10) ? load_val
                 : (!HSELM || HTRANSM == 2'b00) ? 4'd0
                 : (HTRANSM == 2'b11 && beat_q != 4'd0) ? beat_q - 4'd1 : beat_q;
        freeze   = (beat_d != 4'd0);
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            beat_q <= 4'd0;
            hold_q <= 1'b0;
        end else if (HREADYM) begin
            beat_q <= beat_d;
            hold_q <= freeze;
        end
    end

    assign burst_hold = hold_q;
`else
    logic unused_burst;
    assign unused_burst = ^{HTRANSM, HBURSTM};
    assign burst_hold   = 1'b0;
`endif

    // A lock or burst seen with no port selected stays in IDLE so no_port is kept.
    always_comb begin
        addr_d  = addr_q;
        rr_d    = rr_q;
        state_d = state_q;
        if (HMASTLOCKM)
            state_d = (state_q == IDLE) ? IDLE : LOCK;
`ifdef AHB_MTX_RR_BURST_HOLD_EN
        else if (freeze)
            state_d = (state_q == IDLE) ? IDLE : BURST;
`endif
        else if (found) begin
            addr_d  = win;
            rr_d    = (win == PORT_W'(NUM_PORTS - 1)) ? '0 : win + 1'b1;
            state_d = GRANT;
        end else
            state_d = HSELM ? GRANT : IDLE;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            addr_q  <= '0;
            rr_q    <= '0;
            state_q <= IDLE;
        end else if (HREADYM) begin
            addr_q  <= addr_d;
            rr_q    <= rr_d;
            state_q <= state_d;
        end
    end

    assign addr_in_port = addr_q;
    assign no_port      = (state_q == IDLE);
endmodule

// File: tb/tb_ahb_mtx_rr_arb.sv
// tb_ahb_mtx_rr_arb: directed and random checks of the round-robin arbiter
// against a behavioural model (burst cases when AHB_MTX_RR_BURST_HOLD_EN is set).
module tb_ahb_mtx_rr_arb;
    localparam int N = 4;
    localparam int W = 3;

    logic HCLK = 1'b0;
    logic HRESET, HREADYM, HSELM, HMASTLOCKM;
    logic [N-1:0] req_port;
    logic [1:0] HTRANSM;
    logic [2:0] HBURSTM;
    logic [W-1:0] addr_in_port;
    logic no_port, burst_hold;

    int n_chk = 0;
    int n_err = 0;
    int m_grant, m_none, m_ptr, m_beats;

    always #5 HCLK = ~HCLK;

    ahb_mtx_rr_arb #(.NUM_PORTS(N), .PORT_W(W)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .req_port(req_port), .HREADYM(HREADYM),
        .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM),
        .addr_in_port(addr_in_port), .no_port(no_port), .burst_hold(burst_hold)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [N-1:0] r, input logic rdy, input logic sel,
                         input logic lock, input logic [1:0] tr, input logic [2:0] bu);
        req_port = r; HREADYM = rdy; HSELM = sel; HMASTLOCKM = lock; HTRANSM = tr; HBURSTM = bu;
    endtask

    task automatic model_edge();
        if (HRESET) begin
            m_grant = 0; m_none = 1; m_ptr = 0; m_beats = 0;
        end else if (HREADYM) begin
`ifdef AHB_MTX_RR_BURST_HOLD_EN
            if (HSELM && HTRANSM == 2)
                m_beats = (HBURSTM < 2) ? 0 : (HBURSTM < 4) ? 3 : (HBURSTM < 6) ? 7 : 15;
            else if (!HSELM || HTRANSM == 0)
                m_beats = 0;
            else if (HTRANSM == 3 && m_beats > 0)
                m_beats--;
`endif
            if (!(HMASTLOCKM || m_beats > 0)) begin
                if (req_port != 0) begin
                    for (int k = 0; k < N; k++) begin
                        int p;
                        p = (m_ptr + k) % N;
                        if (req_port[p]) begin
                            m_grant = p; m_none = 0; m_ptr = (p + 1) % N;
                            break;
                        end
                    end
                end else
                    m_none = HSELM ? 0 : 1;
            end
        end
    endtask

    task automatic step(input string tag);
        @(posedge HCLK);
        model_edge();
        #1;
        chk({tag, ".addr"}, int'(addr_in_port), m_grant);
        chk({tag, ".no_port"}, int'(no_port), m_none);
        chk({tag, ".hold"}, int'(burst_hold), int'(m_beats > 0));
    endtask

    initial begin
        int rot[4] = '{1, 2, 3, 0};
        HRESET = 1'b1;
        drive(4'hF, 1, 1, 0, 2'b10, 3'b000);
        repeat (2) begin
            step("rst");
            chk("rst_addr", int'(addr_in_port), 0);
            chk("rst_nop", int'(no_port), 1);
        end
        HRESET = 1'b0;
        step("rel");
        chk("first_grant", int'(addr_in_port), 0);
        chk("first_nop", int'(no_port), 0);
        foreach (rot[i]) begin
            step("rot");
            chk("rot_seq", int'(addr_in_port), rot[i]);
        end
        drive(4'b0100, 1, 1, 0, 2'b10, 3'b000);
        step("set_ptr");
        chk("set_ptr", int'(addr_in_port), 2);
        drive(4'b0101, 1, 1, 0, 2'b10, 3'b000);
        step("wrap");
        chk("wrap0", int'(addr_in_port), 0);
        step("skip");
        chk("skip2", int'(addr_in_port), 2);
        HREADYM = 1'b0;
        repeat (3) begin
            step("stall");
            chk("stall_frozen", int'(addr_in_port), 2);
        end
        HREADYM = 1'b1;
        step("wrap2");
        chk("wrap0_again", int'(addr_in_port), 0);
        drive(4'b0010, 1, 1, 0, 2'b10, 3'b000);
        step("pre_lock");
        chk("pre_lock", int'(addr_in_port), 1);
        drive(4'b1101, 1, 1, 1, 2'b10, 3'b000);
        repeat (4) begin
            step("lock");
            chk("lock_hold", int'(addr_in_port), 1);
        end
        HMASTLOCKM = 1'b0;
        step("unlock");
        chk("unlock_grant", int'(addr_in_port), 2);
        drive(4'b0000, 1, 1, 0, 2'b00, 3'b000);
        step("idle_sel");
        chk("idle_sel_addr", int'(addr_in_port), 2);
        chk("idle_sel_nop", int'(no_port), 0);
        HSELM = 1'b0;
        step("idle");
        chk("idle_nop", int'(no_port), 1);
        chk("idle_addr", int'(addr_in_port), 2);
`ifdef AHB_MTX_RR_BURST_HOLD_EN
        drive(4'b0100, 1, 1, 0, 2'b00, 3'b011);
        step("b_pre");
        drive(4'hF, 1, 1, 0, 2'b10, 3'b011);
        step("b_ns");
        chk("b_ns_hold", int'(burst_hold), 1);
        chk("b_ns_addr", int'(addr_in_port), 2);
        foreach (rot[i]) begin
            HTRANSM = (i == 1) ? 2'b01 : 2'b11;
            step("b_beat");
            chk("b_beat_addr", int'(addr_in_port), (i == 3) ? 3 : 2);
            chk("b_beat_hold", int'(burst_hold), (i == 3) ? 0 : 1);
        end
        drive(4'b0100, 1, 1, 0, 2'b00, 3'b011);
        step("e_pre");
        drive(4'hF, 1, 1, 0, 2'b10, 3'b011);
        step("e_ns");
        HTRANSM = 2'b11;
        step("e_seq");
        chk("e_seq_hold", int'(burst_hold), 1);
        HTRANSM = 2'b00;
        step("e_idle");
        chk("e_idle_hold", int'(burst_hold), 0);
        chk("e_idle_addr", int'(addr_in_port), 3);
`endif
        repeat (3000) begin
            HRESET     = ($urandom_range(99) == 0);
            req_port   = N'($urandom);
            HREADYM    = ($urandom_range(3) != 0);
            HSELM      = ($urandom_range(7) != 0);
            HMASTLOCKM = ($urandom_range(9) == 0);
            HTRANSM    = ($urandom_range(1) == 0) ? 2'b11 : 2'($urandom);
            HBURSTM    = 3'($urandom);
            step("rnd");
            chk("rnd_range", int'(addr_in_port < N), 1);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
